alu_cmd_sequencer: RTL and testbench

- Initiator side of the `sync_arith_unit` operand interface.
- Accepts (op, A, B) commands on a valid/ready stream and buffers them in a command queue.
- Drives one command per cycle onto the ALU's registered operand ports (`i_op`, `i_arg_A`, `i_arg_B`), tracks the fixed ALU latency, and captures `o_result`/`o_status` into a response queue.
- Issue is credit-controlled, so no ALU result is ever dropped under response back-pressure.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq_fifo.sv | 50 +++++
 rtl/alu_cmd_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: command/response records and
// the issue state machine encoding.
package alu_seq_pkg;

  localparam int OP_W     = 2;
  localparam int DATA_W   = 4;
  localparam int STATUS_W = 4;

  // One queued operation heading for the ALU operand ports.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
  } alu_cmd_t;

  // One captured ALU answer, tagged with the opcode that produced it.
  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   result;
    logic [STATUS_W-1:0] status;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous FIFO with occupancy count. Pointers carry one extra MSB so
// full and empty are told apart when the index bits match. Pushes while
// full and pops while empty are ignored.
module alu_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q;
  logic [AW:0]      rdPtr_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign count_o = wrPtr_q - rdPtr_q;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q[AW-1:0]];

  // Advance read/write pointers; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + (AW+1)'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a fixed-latency registered ALU. Commands are queued, issued
// one per cycle onto registered operand ports, tracked through a valid/op
// shift register, and their results captured into a response queue.
// Issue is credit-limited so a result always has a response slot waiting.
// N and M must match the widths declared in alu_seq_pkg.
// Optional build macro ALU_SEQ_ERRCNT_EN adds o_err_cnt, a saturating count
// of captured responses whose status is non-zero.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N       = OP_W,
  parameter int M       = DATA_W,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [N-1:0]        i_cmd_op,
  input  logic [M-1:0]        i_cmd_A,
  input  logic [M-1:0]        i_cmd_B,
  output logic [N-1:0]        o_alu_op,
  output logic [M-1:0]        o_alu_A,
  output logic [M-1:0]        o_alu_B,
  input  logic [M-1:0]        i_alu_result,
  input  logic [STATUS_W-1:0] i_alu_status,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [N-1:0]        o_rsp_op,
  output logic [M-1:0]        o_rsp_result,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic                o_busy
`ifdef ALU_SEQ_ERRCNT_EN
  ,
  output logic [7:0]          o_err_cnt
`endif
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int STAGES = ALU_LAT + 1;
  localparam int LAST   = STAGES - 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(DEPTH);

  alu_cmd_t         cmdIn;
  alu_cmd_t         cmdHead;
  alu_rsp_t         rspIn;
  alu_rsp_t         rspHead;
  logic             cmdFull;
  logic             cmdEmpty;
  logic [CNT_W-1:0] cmdCount;
  logic             rspFull;
  logic             rspEmpty;
  logic [CNT_W-1:0] rspCount;

  logic             cmdPush;
  logic             rspPush;
  logic             rspPop;
  logic             issue;
  logic             credit;
  logic [CNT_W:0]   inflightCnt;
  logic [CNT_W:0]   creditSum;
  logic [CNT_W:0]   cmdCountNext;
  logic             cmdEmptyNext;

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [N-1:0]     aluOp_q;
  logic [M-1:0]     aluA_q;
  logic [M-1:0]     aluB_q;
  logic [STAGES-1:0] vldPipe_q;
  logic [N-1:0]     opPipe_q [STAGES];

  assign cmdIn.op = i_cmd_op;
  assign cmdIn.A  = i_cmd_A;
  assign cmdIn.B  = i_cmd_B;

  assign o_cmd_ready = !cmdFull;
  assign cmdPush     = i_cmd_valid && o_cmd_ready;

  alu_seq_fifo #(
    .WIDTH($bits(alu_cmd_t)),
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .push_i (cmdPush),
    .data_i (cmdIn),
    .pop_i  (issue),
    .data_o (cmdHead),
    .full_o (cmdFull),
    .empty_o(cmdEmpty),
    .count_o(cmdCount)
  );

  assign rspIn.op     = opPipe_q[LAST];
  assign rspIn.result = i_alu_result;
  assign rspIn.status = i_alu_status;
  assign rspPush      = vldPipe_q[LAST] && !rspFull;
  assign o_rsp_valid  = !rspEmpty;
  assign rspPop       = o_rsp_valid && i_rsp_ready;

  alu_seq_fifo #(
    .WIDTH($bits(alu_rsp_t)),
    .DEPTH(DEPTH)
  ) u_rsp_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .push_i (rspPush),
    .data_i (rspIn),
    .pop_i  (rspPop),
    .data_o (rspHead),
    .full_o (rspFull),
    .empty_o(rspEmpty),
    .count_o(rspCount)
  );

  // Response outputs read zero whenever nothing is waiting, including reset.
  assign o_rsp_op     = o_rsp_valid ? rspHead.op     : '0;
  assign o_rsp_result = o_rsp_valid ? rspHead.result : '0;
  assign o_rsp_status = o_rsp_valid ? rspHead.status : '0;

  // Count results still travelling through the ALU.
  always_comb begin
    inflightCnt = '0;
    for (int i = 0; i < STAGES; i++) begin
      inflightCnt = inflightCnt + (CNT_W+1)'(vldPipe_q[i]);
    end
  end

  // A command may only go out if its result is guaranteed a response slot;
  // a pop in the same cycle is deliberately not credited.
  assign creditSum    = {1'b0, rspCount} + inflightCnt;
  assign credit       = (creditSum < DEPTH_LIM);
  assign issue        = !cmdEmpty && credit;
  assign cmdCountNext = {1'b0, cmdCount} + (CNT_W+1)'(cmdPush) - (CNT_W+1)'(issue);
  assign cmdEmptyNext = (cmdCountNext == '0);

  // Next-state logic: follows command queue occupancy and credit availability.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!cmdEmptyNext) state_d = RUN;
      end
      RUN: begin
        if (cmdEmptyNext)               state_d = IDLE;
        else if (!cmdEmpty && !credit)  state_d = STALL;
      end
      STALL: begin
        if (cmdEmptyNext)  state_d = IDLE;
        else if (credit)   state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Drive operands on issue and shift each issue's valid bit and opcode
  // toward the capture point.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      aluOp_q   <= '0;
      aluA_q    <= '0;
      aluB_q    <= '0;
      vldPipe_q <= '0;
      for (int i = 0; i < STAGES; i++) opPipe_q[i] <= '0;
    end else begin
      if (issue) begin
        aluOp_q <= cmdHead.op;
        aluA_q  <= cmdHead.A;
        aluB_q  <= cmdHead.B;
      end
      vldPipe_q[0] <= issue;
      opPipe_q[0]  <= cmdHead.op;
      for (int i = 1; i < STAGES; i++) begin
        vldPipe_q[i] <= vldPipe_q[i-1];
        opPipe_q[i]  <= opPipe_q[i-1];
      end
    end
  end

  assign o_alu_op = aluOp_q;
  assign o_alu_A  = aluA_q;
  assign o_alu_B  = aluB_q;
  assign o_busy   = (state_q != IDLE) || (|vldPipe_q) || o_rsp_valid;

`ifdef ALU_SEQ_ERRCNT_EN
  logic [7:0] errCnt_q;

  // Saturating tally of captured responses that carried a non-zero status.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      errCnt_q <= '0;
    end else if (rspPush && (i_alu_status != '0) && (errCnt_q != 8'hFF)) begin
      errCnt_q <= errCnt_q + 8'd1;
    end
  end

  assign o_err_cnt = errCnt_q;
`else
  // Without the error counter nothing extra is observed about status.
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural
// registered ALU. Build with ALU_SEQ_ERRCNT_EN to include the error counter.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int N = 2;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         resetN;
  logic         cmdValid;
  logic         cmdReady;
  logic [N-1:0] cmdOp;
  logic [M-1:0] cmdA;
  logic [M-1:0] cmdB;
  logic [N-1:0] aluOp;
  logic [M-1:0] aluA;
  logic [M-1:0] aluB;
  logic [M-1:0] aluResult;
  logic [3:0]   aluStatus;
  logic         rspValid;
  logic         rspReady;
  logic [N-1:0] rspOp;
  logic [M-1:0] rspResult;
  logic [3:0]   rspStatus;
  logic         busy;
`ifdef ALU_SEQ_ERRCNT_EN
  logic [7:0]   errCnt;
`endif

  int checksPassed = 0;
  int checksTotal  = 0;
  int checksFailed = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(N), .M(M), .DEPTH(4), .ALU_LAT(1)) dut (
    .i_clk       (clk),
    .i_reset     (resetN),
    .i_cmd_valid (cmdValid),
    .o_cmd_ready (cmdReady),
    .i_cmd_op    (cmdOp),
    .i_cmd_A     (cmdA),
    .i_cmd_B     (cmdB),
    .o_alu_op    (aluOp),
    .o_alu_A     (aluA),
    .o_alu_B     (aluB),
    .i_alu_result(aluResult),
    .i_alu_status(aluStatus),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_op    (rspOp),
    .o_rsp_result(rspResult),
    .o_rsp_status(rspStatus),
`ifdef ALU_SEQ_ERRCNT_EN
    .o_err_cnt   (errCnt),
`endif
    .o_busy      (busy)
  );

  // Behavioural ALU: samples operands on the clock, result settles one cycle later.
  logic [N-1:0] mOp;
  logic [M-1:0] mA;
  logic [M-1:0] mB;
  logic [M:0]   mWide;
  logic         forceErr;

  always @(posedge clk) begin
    mOp <= aluOp;
    mA  <= aluA;
    mB  <= aluB;
  end

  always_comb begin
    case (mOp)
      2'b00:   mWide = {1'b0, mA} + {1'b0, mB};
      2'b01:   mWide = {1'b0, mA} - {1'b0, mB};
      2'b10:   mWide = {1'b0, mA & mB};
      default: mWide = {1'b0, ~mA};
    endcase
    aluResult = mWide[M-1:0];
    aluStatus = forceErr ? 4'b0001 : {1'b0, mWide[M], mWide[M-1], (mWide[M-1:0] == '0)};
  end

  task automatic applyStimulus(input logic v, input logic [N-1:0] op,
                               input logic [M-1:0] a, input logic [M-1:0] b);
    cmdValid = v;
    cmdOp    = op;
    cmdA     = a;
    cmdB     = b;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case something never terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [N-1:0] bOp  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [M-1:0] bA   [4] = '{4'b0011, 4'b1100, 4'b0010, 4'b1011};
  logic [M-1:0] bB   [4] = '{4'b1111, 4'b0011, 4'b0011, 4'b0101};
  logic [M-1:0] bRes [4] = '{4'b0010, 4'b1001, 4'b0010, 4'b0100};
  logic [3:0]   bSt  [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b0000};

  initial begin
    int  sent;
    int  got;
    logic pushNow;
    logic popNow;
    logic seenValid;
    logic [N-1:0] hOp;
    logic [M-1:0] hRes;
    logic [3:0]   hSt;

    resetN   = 1'b0;
    rspReady = 1'b0;
    forceErr = 1'b0;
    applyStimulus(1'b0, '0, '0, '0);
    repeat (2) tick();

    $display("[TB] reset values");
    checkOutput("reset cmd_ready", 16'(cmdReady), 16'd1);
    checkOutput("reset rsp_valid", 16'(rspValid), 16'd0);
    checkOutput("reset busy",      16'(busy),     16'd0);
    checkOutput("reset alu_op",    16'(aluOp),    16'd0);
    checkOutput("reset alu_A",     16'(aluA),     16'd0);
    checkOutput("reset alu_B",     16'(aluB),     16'd0);
    checkOutput("reset rsp_result",16'(rspResult),16'd0);
    checkOutput("reset rsp_status",16'(rspStatus),16'd0);
    resetN = 1'b1;
    tick();

    $display("[TB] single command");
    applyStimulus(1'b1, 2'b00, 4'b0011, 4'b0001);
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("single busy queued", 16'(busy), 16'd1);
    tick();
    checkOutput("single alu_op", 16'(aluOp), 16'h0);
    checkOutput("single alu_A",  16'(aluA),  16'h3);
    checkOutput("single alu_B",  16'(aluB),  16'h1);
    checkOutput("single no early rsp e1", 16'(rspValid), 16'd0);
    tick();
    checkOutput("single no early rsp e2", 16'(rspValid), 16'd0);
    tick();
    checkOutput("single rsp_valid",  16'(rspValid),  16'd1);
    checkOutput("single rsp_op",     16'(rspOp),     16'h0);
    checkOutput("single rsp_result", 16'(rspResult), 16'h4);
    checkOutput("single rsp_status", 16'(rspStatus), 16'h0);
    checkOutput("single busy pending", 16'(busy), 16'd1);
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("single rsp popped", 16'(rspValid), 16'd0);
    checkOutput("single busy clear", 16'(busy),     16'd0);

    $display("[TB] burst of four");
    rspReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) applyStimulus(1'b1, bOp[k], bA[k], bB[k]);
      else       applyStimulus(1'b0, '0, '0, '0);
      tick();
      if (k >= 1 && k <= 4) begin
        checkOutput($sformatf("burst alu_op %0d", k-1), 16'(aluOp), 16'(bOp[k-1]));
        checkOutput($sformatf("burst alu_A %0d",  k-1), 16'(aluA),  16'(bA[k-1]));
        checkOutput($sformatf("burst alu_B %0d",  k-1), 16'(aluB),  16'(bB[k-1]));
      end
      if (k >= 3 && k <= 6) begin
        checkOutput($sformatf("burst rsp_valid %0d",  k-3), 16'(rspValid),  16'd1);
        checkOutput($sformatf("burst rsp_op %0d",     k-3), 16'(rspOp),     16'(bOp[k-3]));
        checkOutput($sformatf("burst rsp_result %0d", k-3), 16'(rspResult), 16'(bRes[k-3]));
        checkOutput($sformatf("burst rsp_status %0d", k-3), 16'(rspStatus), 16'(bSt[k-3]));
      end
    end
    checkOutput("burst drained valid", 16'(rspValid), 16'd0);
    checkOutput("burst drained busy",  16'(busy),     16'd0);
    rspReady = 1'b0;

    $display("[TB] back-pressure");
    sent = 0;
    for (int k = 0; k < 20 && sent < 8; k++) begin
      applyStimulus(1'b1, 2'b00, 4'(sent), 4'b0001);
      pushNow = cmdReady;
      tick();
      if (pushNow) sent++;
    end
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("bp all pushed", 16'(sent), 16'd8);
    repeat (2) tick();
    checkOutput("bp cmd_ready low", 16'(cmdReady),      16'd0);
    checkOutput("bp rsp captured",  16'(dut.rspCount),  16'd4);
    checkOutput("bp state stall",   16'(dut.state_q),   16'(STALL));
    checkOutput("bp head result",   16'(rspResult),     16'h1);

    applyStimulus(1'b1, 2'b01, 4'b1111, 4'b0001);
    repeat (3) tick();
    checkOutput("full push refused", 16'(cmdReady),     16'd0);
    checkOutput("full no extra",     16'(dut.cmdCount), 16'd4);

    rspReady = 1'b1;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      popNow  = rspValid;
      hOp     = rspOp;
      hRes    = rspResult;
      hSt     = rspStatus;
      pushNow = cmdValid && cmdReady;
      tick();
      if (pushNow) applyStimulus(1'b0, '0, '0, '0);
      if (popNow) begin
        if (got < 8) begin
          checkOutput($sformatf("drain op %0d", got),     16'(hOp),  16'h0);
          checkOutput($sformatf("drain result %0d", got), 16'(hRes), 16'(got + 1));
          checkOutput($sformatf("drain status %0d", got), 16'(hSt),  (got == 7) ? 16'h2 : 16'h0);
        end else if (got == 8) begin
          checkOutput("drain held op",     16'(hOp),  16'h1);
          checkOutput("drain held result", 16'(hRes), 16'hE);
          checkOutput("drain held status", 16'(hSt),  16'h2);
        end
        got++;
      end
    end
    checkOutput("drain count", 16'(got),  16'd9);
    checkOutput("drain busy",  16'(busy), 16'd0);
    rspReady = 1'b0;

    $display("[TB] reset mid-operation");
    sent = 0;
    for (int k = 0; k < 20 && sent < 7; k++) begin
      applyStimulus(1'b1, 2'b10, 4'(sent), 4'b1111);
      pushNow = cmdReady;
      tick();
      if (pushNow) sent++;
    end
    applyStimulus(1'b0, '0, '0, '0);
    repeat (2) tick();
    rspReady = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'h8, 4'h1);
    tick();
    applyStimulus(1'b1, 2'b00, 4'h9, 4'h1);
    tick();
    rspReady = 1'b0;
    tick();
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("pre-reset inflight", 16'(dut.inflightCnt), 16'd2);
    checkOutput("pre-reset queued",   16'(dut.cmdCount),    16'd3);
    checkOutput("pre-reset busy",     16'(busy),            16'd1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midrst cmd_ready",  16'(cmdReady),  16'd1);
    checkOutput("midrst rsp_valid",  16'(rspValid),  16'd0);
    checkOutput("midrst busy",       16'(busy),      16'd0);
    checkOutput("midrst alu_op",     16'(aluOp),     16'd0);
    checkOutput("midrst alu_A",      16'(aluA),      16'd0);
    checkOutput("midrst alu_B",      16'(aluB),      16'd0);
    checkOutput("midrst rsp_op",     16'(rspOp),     16'd0);
    checkOutput("midrst rsp_result", 16'(rspResult), 16'd0);
    checkOutput("midrst rsp_status", 16'(rspStatus), 16'd0);
    tick();
    #2 resetN = 1'b1;
    seenValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rspValid) seenValid = 1'b1;
    end
    checkOutput("post-reset no rsp",  16'(seenValid), 16'd0);
    checkOutput("post-reset idle",    16'(busy),      16'd0);

`ifdef ALU_SEQ_ERRCNT_EN
    $display("[TB] error counter saturation");
    checkOutput("errcnt after reset", 16'(errCnt), 16'h00);
    forceErr = 1'b1;
    rspReady = 1'b1;
    sent = 0;
    got  = 0;
    for (int k = 0; k < 400; k++) begin
      applyStimulus(sent < 300, 2'b00, 4'(sent), 4'h1);
      pushNow = cmdValid && cmdReady;
      popNow  = rspValid;
      tick();
      if (pushNow) sent++;
      if (popNow)  got++;
    end
    applyStimulus(1'b0, '0, '0, '0);
    checkOutput("errcnt responses", 16'(got),    16'd300);
    checkOutput("errcnt saturated", 16'(errCnt), 16'hFF);
    repeat (3) tick();
    checkOutput("errcnt holds",     16'(errCnt), 16'hFF);
    forceErr = 1'b0;
    rspReady = 1'b0;
`else
    $display("[TB] error counter option not built in");
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
